// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares one combinational 8-bit ALU between two requesters.
//   Each operation goes through three states:
//     IDLE - arbitrate between the requesters and register the operands
//     EXEC - the ALU settles; capture its result and masked flags
//     RESP - hold the response until the consumer takes it
//   Arbitration is round-robin. The pointer moves to the other requester
//   whenever a response is consumed.
//
// Ports
//   clk, rst                   clock and asynchronous active-high reset
//   reqN_valid / reqN_ready    request handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_op    request operands and opcode
//   alu_a, alu_b, alu_op       registered operands driven to the ALU
//   alu_c, alu_<flag>          ALU result and raw flags
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_c, rsp_flags   response owner, result, and flags
//                              {carry,borrow,equal,less,more}
//   busy                       high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
  parameter int DW  = 8,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_c,
  input  logic           alu_carry,
  input  logic           alu_borrow,
  input  logic           alu_equal,
  input  logic           alu_less,
  input  logic           alu_more,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_c,
  output logic [4:0]     rsp_flags,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_CMP = OPW'(6);
  localparam logic [OPW-1:0] OP_INV = OPW'(7);

  state_t         state_reg, state_next;
  logic           rr_ptr_reg;
  logic [DW-1:0]  alu_a_reg, alu_b_reg;
  logic [OPW-1:0] alu_op_reg;
  logic           rsp_id_reg;
  logic [DW-1:0]  rsp_c_reg;
  logic [4:0]     rsp_flags_reg;

  logic           grant;        // 1 selects requester 1
  logic           accept;
  logic [DW-1:0]  masked_c;
  logic [4:0]     masked_flags;

  // The ALU drives every flag on every opcode. Only the flags that the
  // current opcode actually updates are passed through; the rest are stale.
  always_comb begin
    masked_c     = alu_c;
    masked_flags = 5'b00000;
    case (alu_op_reg)
      OP_ADD:  masked_flags = {alu_carry, 4'b0000};
      OP_SUB:  masked_flags = {1'b0, alu_borrow, 3'b000};
      OP_CMP: begin
        masked_flags = {2'b00, alu_equal, alu_less, alu_more};
        masked_c     = '0;
      end
      OP_INV:  masked_c = '0;
      default: masked_flags = 5'b00000;
    endcase
  end

  // Arbitration. When both requesters are valid, the round-robin pointer
  // breaks the tie.
  always_comb begin
    grant      = req1_valid && (!req0_valid || rr_ptr_reg);
    accept     = (state_reg == IDLE) && (req0_valid || req1_valid);
    req0_ready = (state_reg == IDLE) && req0_valid && !grant;
    req1_ready = (state_reg == IDLE) && req1_valid && grant;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= 1'b0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_op_reg    <= '0;
      rsp_id_reg    <= 1'b0;
      rsp_c_reg     <= '0;
      rsp_flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (accept) begin
          alu_a_reg  <= grant ? req1_a  : req0_a;
          alu_b_reg  <= grant ? req1_b  : req0_b;
          alu_op_reg <= grant ? req1_op : req0_op;
          rsp_id_reg <= grant;
        end
        EXEC: begin
          rsp_c_reg     <= masked_c;
          rsp_flags_reg <= masked_flags;
        end
        RESP: if (rsp_ready) rr_ptr_reg <= ~rsp_id_reg;
        default: ;
      endcase
    end
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_op    = alu_op_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_id    = rsp_id_reg;
  assign rsp_c     = rsp_c_reg;
  assign rsp_flags = rsp_flags_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
//   Directed, table-driven checks of the shared-ALU scheduler. The bench
//   contains a behavioural ALU that drives every flag on every opcode, so a
//   flag that is not masked shows up in the response. Hand-written sequences
//   cover fairness and reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic [7:0] alu_a, alu_b, alu_c;
  logic [2:0] alu_op;
  logic       alu_carry, alu_borrow, alu_equal, alu_less, alu_more;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_c;
  logic [4:0] rsp_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.DW(8), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .alu_carry(alu_carry), .alu_borrow(alu_borrow), .alu_equal(alu_equal),
    .alu_less(alu_less), .alu_more(alu_more),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_flags(rsp_flags), .busy(busy)
  );

  // Behavioural ALU. Every flag is driven on every opcode.
  logic [8:0] sum;
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_op)
      3'd0:    alu_c = sum[7:0];
      3'd1:    alu_c = alu_a - alu_b;
      3'd2:    alu_c = alu_a ^ alu_b;
      3'd3:    alu_c = alu_a & alu_b;
      3'd4:    alu_c = ~(alu_a | alu_b);
      3'd5:    alu_c = ~(alu_a & alu_b);
      3'd6:    alu_c = alu_a - alu_b;
      default: alu_c = sum[7:0];
    endcase
    alu_carry  = sum[8];
    alu_borrow = alu_a < alu_b;
    alu_equal  = alu_a == alu_b;
    alu_less   = alu_a < alu_b;
    alu_more   = alu_a > alu_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Runs one operation from a single requester. While the response is held,
  // the other requester raises valid and then drops it again; it must never
  // see ready and must not be granted.
  task automatic run_op(input logic id, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int hold,
                        input logic [7:0] exp_c, input logic [4:0] exp_f);
    int waited = 0;
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(id, 1'b1, op, a, b);
    #1;
    while (!(id ? req1_ready : req0_ready) && waited < 10) begin
      @(negedge clk); #1; waited++;
    end
    check("ready_seen", {31'b0, id ? req1_ready : req0_ready}, 32'd1);
    check("ready_other", {31'b0, id ? req0_ready : req1_ready}, 32'd0);
    @(negedge clk);                       // accept edge passed: EXEC
    set_req(id, 1'b0, op, a, b);
    check("exec_busy", {31'b0, busy}, 32'd1);
    check("exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("alu_a", {24'b0, alu_a}, {24'b0, a});
    check("alu_b", {24'b0, alu_b}, {24'b0, b});
    check("alu_op", {29'b0, alu_op}, {29'b0, op});
    @(negedge clk);                       // RESP
    check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("rsp_id", {31'b0, rsp_id}, {31'b0, id});
    check("rsp_c", {24'b0, rsp_c}, {24'b0, exp_c});
    check("rsp_flags", {27'b0, rsp_flags}, {27'b0, exp_f});
    if (hold > 0) set_req(!id, 1'b1, 3'd0, 8'h11, 8'h22);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_c", {24'b0, rsp_c}, {24'b0, exp_c});
      check("hold_flags", {27'b0, rsp_flags}, {27'b0, exp_f});
      check("hold_id", {31'b0, rsp_id}, {31'b0, id});
      check("hold_no_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
    end
    set_req(!id, 1'b0, 3'd0, 8'h00, 8'h00);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("done_busy", {31'b0, busy}, 32'd0);
    $display("op id=%0d op=%0d a=%02h b=%02h -> c=%02h flags=%05b", id, op, a, b, exp_c, exp_f);
  endtask

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         hold;
    logic [7:0] exp_c;
    logic [4:0] exp_f;
  } vec_t;

  vec_t vecs[11];
  int   grants[$];

  initial begin
    //          id    op    a      b      hold  c      flags {C,B,E,L,M}
    vecs[0]  = '{1'b0, 3'd0, 8'hF0, 8'h20, 0, 8'h10, 5'b10000};  // ADD with carry
    vecs[1]  = '{1'b1, 3'd6, 8'd5,  8'd9,  4, 8'h00, 5'b00010};  // CMP less, held
    vecs[2]  = '{1'b0, 3'd1, 8'd3,  8'd5,  0, 8'hFE, 5'b01000};  // SUB with borrow
    vecs[3]  = '{1'b0, 3'd2, 8'd3,  8'd5,  0, 8'h06, 5'b00000};  // XOR, borrow masked
    vecs[4]  = '{1'b1, 3'd3, 8'hF0, 8'h3C, 1, 8'h30, 5'b00000};  // AND
    vecs[5]  = '{1'b0, 3'd4, 8'h00, 8'h0F, 0, 8'hF0, 5'b00000};  // NOR
    vecs[6]  = '{1'b1, 3'd5, 8'hFF, 8'h0F, 0, 8'hF0, 5'b00000};  // NAND
    vecs[7]  = '{1'b0, 3'd7, 8'd7,  8'd1,  0, 8'h00, 5'b00000};  // unused opcode
    vecs[8]  = '{1'b1, 3'd0, 8'hFF, 8'h01, 0, 8'h00, 5'b10000};  // ADD wraps
    vecs[9]  = '{1'b0, 3'd6, 8'd9,  8'd9,  0, 8'h00, 5'b00100};  // CMP equal
    vecs[10] = '{1'b1, 3'd6, 8'd200, 8'd3, 0, 8'h00, 5'b00001};  // CMP more

    rst = 1'b1; rsp_ready = 1'b0;
    set_req(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_outputs", {8'b0, alu_a, alu_b, 5'b0, alu_op}, 32'd0);
    check("rst_rsp", {18'b0, rsp_id, rsp_c, rsp_flags}, 32'd0);
    check("rst_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 32'd0);

    for (int v = 0; v < 11; v++)
      run_op(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].hold,
             vecs[v].exp_c, vecs[v].exp_f);

    // Fairness: both requesters valid continuously after a fresh reset.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    set_req(1'b0, 1'b1, 3'd0, 8'h01, 8'h02);
    set_req(1'b1, 1'b1, 3'd0, 8'h03, 8'h04);
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      check("ready_exclusive", {31'b0, req0_ready & req1_ready}, 32'd0);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      @(negedge clk);
    end
    check("grant_count", grants.size(), 32'd4);
    for (int g = 0; g < grants.size() && g < 4; g++)
      check("grant_order", grants[g], g % 2);
    $display("fairness grants=%p", grants);
    set_req(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    rsp_ready = 1'b0;
    check("fair_idle", {31'b0, busy}, 32'd0);

    // Reset in EXEC: set the pointer to 1, start a req1 grant, then reset.
    run_op(1'b0, 3'd0, 8'h01, 8'h01, 0, 8'h02, 5'b00000);
    set_req(1'b0, 1'b1, 3'd2, 8'hAA, 8'h55);
    set_req(1'b1, 1'b1, 3'd1, 8'h10, 8'h01);
    #1;
    check("pre_rst_grant1", {30'b0, req0_ready, req1_ready}, 32'd1);
    @(negedge clk);
    check("pre_rst_exec", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_alu_a", {24'b0, alu_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_grant0", {30'b0, req0_ready, req1_ready}, 32'd2);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    check("post_rst_alu_a", {24'b0, alu_a}, 32'h000000AA);
    @(negedge clk);
    check("post_rst_rsp_id", {31'b0, rsp_id}, 32'd0);
    check("post_rst_rsp_c", {24'b0, rsp_c}, 32'h000000FF);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("end_idle", {31'b0, busy}, 32'd0);
    $display("reset-in-exec sequence done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
